depth_feed_ctrl: RTL and testbench

//  Sequencer in front of the depth-increase counter datapath. Accepts an ASCII byte

---
 rtl/depth_feed_pkg.sv | 31 +++
 rtl/ascii_dec_accum.sv | 89 ++++++++
 rtl/depth_feed_ctrl.sv | 163 ++++++++++++++++
 tb/tb_depth_feed_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/depth_feed_pkg.sv
// ---------------------------------------------------------------------------
// depth_feed_pkg
//   Shared types and constants for the depth feed sequencer.
//   - state_e     : sequencer states
//   - ASCII_*     : byte codes recognised by the parser
//   - DEFAULT_DATA_W : default width of parsed samples and the sample counter
//   - is_ascii_digit : helper, true for '0'..'9'
// ---------------------------------------------------------------------------
package depth_feed_pkg;

  localparam int DEFAULT_DATA_W = 16;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_CR   = 8'h0D;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    EMIT  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_e;

  function automatic logic is_ascii_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

endpackage

// File: rtl/ascii_dec_accum.sv
// ---------------------------------------------------------------------------
// ascii_dec_accum
//   Decodes one ASCII byte per accepted beat and folds decimal digits into
//   an accumulator (acc = acc*10 + digit). Overflow handling is selected by
//   the DEPTH_SAT_EN macro:
//     defined     : accumulator clamps at 2^DATA_W-1, ovf never asserted
//     not defined : accumulator wraps modulo 2^DATA_W, ovf pulses
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     clr             clear accumulator and digit flag (wins over byte_vld)
//     byte_vld        byte_data is being accepted this cycle
//     byte_data       ASCII byte
//     is_term         byte is LF or CR
//     is_bad          byte is neither a digit nor a terminator
//     acc_next        accumulator value after this cycle
//     has_digit_next  digit flag after this cycle
//     ovf             accepted digit overflowed the accumulator (wrap mode)
// ---------------------------------------------------------------------------
module ascii_dec_accum
  import depth_feed_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              byte_vld,
  input  logic [7:0]        byte_data,
  output logic              is_term,
  output logic              is_bad,
  output logic [DATA_W-1:0] acc_next,
  output logic              has_digit_next,
  output logic              ovf
);

  // Four extra bits hold acc*10+9 for any acc without loss.
  localparam int WIDE_W = DATA_W + 4;
  localparam logic [WIDE_W-1:0] ACC_MAX = {4'b0, {DATA_W{1'b1}}};

  logic [DATA_W-1:0] acc_q, acc_d;
  logic              has_digit_q, has_digit_d;
  logic              is_dig;
  logic [3:0]        digit_val;
  logic [WIDE_W-1:0] wide;

  always_comb begin
    is_dig    = is_ascii_digit(byte_data);
    is_term   = (byte_data == ASCII_LF) || (byte_data == ASCII_CR);
    is_bad    = !is_dig && !is_term;
    // '0'..'9' are 0x30..0x39, so the low nibble is the digit value.
    digit_val = byte_data[3:0];
    wide      = ({4'b0, acc_q} * WIDE_W'(10)) + WIDE_W'(digit_val);

    acc_d       = acc_q;
    has_digit_d = has_digit_q;
    ovf         = 1'b0;

    if (clr) begin
      acc_d       = '0;
      has_digit_d = 1'b0;
    end else if (byte_vld && is_dig) begin
      has_digit_d = 1'b1;
      if (wide > ACC_MAX) begin
`ifdef DEPTH_SAT_EN
        acc_d = '1;
`else
        acc_d = wide[DATA_W-1:0];
        ovf   = 1'b1;
`endif
      end else begin
        acc_d = wide[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      has_digit_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      has_digit_q <= has_digit_d;
    end
  end

  assign acc_next       = acc_d;
  assign has_digit_next = has_digit_d;

endmodule

// File: rtl/depth_feed_ctrl.sv
// ---------------------------------------------------------------------------
// depth_feed_ctrl
//   Sequencer in front of the depth-increase counter datapath. Parses a
//   newline-separated ASCII decimal stream, clears the datapath once per
//   run, strobes one sample per parsed number, drains the datapath pipeline
//   and then reports done. Optional macro: DEPTH_SAT_EN (accumulator
//   saturates instead of wrapping and raising parse_err).
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     start          begin a run (only in IDLE or DONE)
//     in_valid/in_data/in_last/in_ready  byte stream handshake
//     dp_rst         one-cycle datapath clear at run start
//     dp_en          one-cycle sample strobe, dp_height valid with it
//     dp_height      last emitted sample (registered)
//     busy           run in progress
//     done           run finished, held until next start
//     sample_count   samples emitted this run
//     parse_err      sticky per run: illegal byte or accumulator overflow
// ---------------------------------------------------------------------------
module depth_feed_ctrl
  import depth_feed_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              dp_rst,
  output logic              dp_en,
  output logic [DATA_W-1:0] dp_height,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sample_count,
  output logic              parse_err
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [DATA_W-1:0] height_q, height_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              err_q, err_d;

  logic              accept;
  logic              acc_clr;
  logic              is_term;
  logic              is_bad;
  logic [DATA_W-1:0] acc_next;
  logic              has_digit_next;
  logic              ovf;

  assign accept  = in_valid && (state_q == ACCUM);
  // The accumulator is emptied at run start and right after each sample.
  assign acc_clr = (state_q == CLEAR) || (state_q == EMIT);

  ascii_dec_accum #(
    .DATA_W (DATA_W)
  ) u_accum (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr            (acc_clr),
    .byte_vld       (accept),
    .byte_data      (in_data),
    .is_term        (is_term),
    .is_bad         (is_bad),
    .acc_next       (acc_next),
    .has_digit_next (has_digit_next),
    .ovf            (ovf)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    drain_cnt_d = '0;
    height_d    = height_q;
    count_d     = count_q;
    err_d       = err_q;
    in_ready    = 1'b0;
    dp_rst      = 1'b0;
    dp_en       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        dp_rst  = 1'b1;
        busy    = 1'b1;
        count_d = '0;
        err_d   = 1'b0;
        last_d  = 1'b0;
        state_d = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) begin
          if (is_bad || ovf) err_d = 1'b1;
          // A pending number is flushed by a terminator or by end of stream;
          // dp_height is loaded here so it is already valid in the EMIT cycle.
          if (has_digit_next && (is_term || in_last)) begin
            state_d  = EMIT;
            last_d   = in_last;
            height_d = acc_next;
          end else if (in_last) begin
            state_d = DRAIN;
          end
        end
      end
      EMIT: begin
        dp_en   = 1'b1;
        busy    = 1'b1;
        count_d = count_q + DATA_W'(1);
        state_d = last_q ? DRAIN : ACCUM;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt_q == DRAIN_LAST) state_d = DONE;
        else drain_cnt_d = drain_cnt_q + CNT_W'(1);
      end
      DONE: begin
        done = 1'b1;
        if (start) state_d = CLEAR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b0;
      drain_cnt_q <= '0;
      height_q    <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      drain_cnt_q <= drain_cnt_d;
      height_q    <= height_d;
      count_q     <= count_d;
      err_q       <= err_d;
    end
  end

  assign dp_height    = height_q;
  assign sample_count = count_q;
  assign parse_err    = err_q;

endmodule

// File: tb/tb_depth_feed_ctrl.sv
// ---------------------------------------------------------------------------
// tb_depth_feed_ctrl
//   Directed bench for depth_feed_ctrl. A string-level model derives the
//   expected sample list, error flag and completion latency of each run; a
//   compare process checks every emitted sample and the running count.
// ---------------------------------------------------------------------------
module tb_depth_feed_ctrl;

  localparam int DATA_W = 16;
  localparam int DRAIN  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              dp_rst;
  logic              dp_en;
  logic [DATA_W-1:0] dp_height;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] sample_count;
  logic              parse_err;

  always #5 clk = ~clk;

  depth_feed_ctrl #(
    .DATA_W       (DATA_W),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .dp_rst       (dp_rst),
    .dp_en        (dp_en),
    .dp_height    (dp_height),
    .busy         (busy),
    .done         (done),
    .sample_count (sample_count),
    .parse_err    (parse_err)
  );

  int     n_checks = 0;
  int     n_fail = 0;
  int     emits_seen = 0;
  int     rst_pulses = 0;
  int     exp_n = 0;
  bit     exp_err = 0;
  bit     exp_pend = 0;
  bit     prev_dp_rst = 0;
  longint exp_q[$];
  longint cur_exp;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Final sample value as the datapath must see it, from the full decimal value.
  function automatic void push_sample(input longint num);
    if (num > 65535) begin
`ifdef DEPTH_SAT_EN
      exp_q.push_back(65535);
`else
      exp_q.push_back(num % 65536);
      exp_err = 1'b1;
`endif
    end else begin
      exp_q.push_back(num);
    end
  endfunction

  function automatic void build_model(input string s);
    longint num = 0;
    bit     has = 0;
    int     c;
    int     before_last = 0;
    exp_q.delete();
    exp_err = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      if (i == s.len() - 1) before_last = exp_q.size();
      c = s[i];
      if (c >= 48 && c <= 57) begin
        num = num * 10 + (c - 48);
        has = 1'b1;
      end else if (c == 10 || c == 13) begin
        if (has) begin
          push_sample(num);
          num = 0;
          has = 1'b0;
        end
      end else begin
        exp_err = 1'b1;
      end
    end
    if (has) push_sample(num);
    exp_pend = (exp_q.size() > before_last);
    exp_n    = exp_q.size();
  endfunction

  // Compare process: every strobe must carry the next expected sample, and
  // the counter must equal the strobes seen since the run's clear.
  always @(negedge clk) begin
    if (!rst_n) begin
      emits_seen  = 0;
      prev_dp_rst = 1'b0;
    end else begin
      if (dp_rst) begin
        emits_seen = 0;
        rst_pulses++;
      end else begin
        chk("sample_count_running", sample_count, emits_seen);
      end
      if (prev_dp_rst) chk("parse_err_after_clear", parse_err, 0);
      if (dp_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_emit: got dp_height %0d, expected no strobe", dp_height);
        end else begin
          cur_exp = exp_q.pop_front();
          chk("dp_height_sample", dp_height, cur_exp);
        end
        emits_seen++;
      end
      chk("busy_done_exclusive", busy & done, 0);
      prev_dp_rst = dp_rst;
    end
  end

  task automatic feed_byte(input logic [7:0] b, input logic last, input bit rnd, output bit ok);
    int waited = 0;
    bit acc = 1'b0;
    if (rnd) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    ok = acc;
    chk("byte_accepted", acc, 1);
  endtask

  task automatic run_stream(input string s, input bit rnd, input bit mid_start);
    bit ok;
    int lat;
    int n = s.len();
    build_model(s);
    rst_pulses = 0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("clear_dp_rst", dp_rst, 1);
    chk("clear_busy", busy, 1);
    for (int i = 0; i < n; i++) begin
      if (mid_start && i == n / 2) start = 1'b1;
      feed_byte(s[i], (i == n - 1), rnd, ok);
      start = 1'b0;
      if (!ok) return;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 100);
    chk("done_latency", lat, DRAIN + 1 + (exp_pend ? 1 : 0));
    chk("done_flag", done, 1);
    chk("busy_at_done", busy, 0);
    chk("ready_at_done", in_ready, 0);
    chk("sample_count_final", sample_count, exp_n);
    chk("parse_err_final", parse_err, exp_err);
    chk("samples_left_over", exp_q.size(), 0);
    chk("dp_rst_pulses", rst_pulses, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_dp_rst"}, dp_rst, 0);
    chk({tag, "_dp_en"}, dp_en, 0);
    chk({tag, "_dp_height"}, dp_height, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sample_count"}, sample_count, 0);
    chk({tag, "_parse_err"}, parse_err, 0);
  endtask

  initial begin
    bit ok;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic three-sample stream.
    run_stream("199\n200\n208\n", 1'b0, 1'b0);
    chk("pin_run1_height", dp_height, 208);
    chk("pin_run1_count", sample_count, 3);
    chk("pin_run1_err", parse_err, 0);

    // CR/LF and blank line, final number closed by in_last only.
    run_stream("12\015\n\n34", 1'b0, 1'b0);
    chk("pin_crlf_height", dp_height, 34);
    chk("pin_crlf_count", sample_count, 2);

    // Illegal byte dropped.
    run_stream("1x2\n", 1'b0, 1'b0);
    chk("pin_bad_height", dp_height, 12);
    chk("pin_bad_err", parse_err, 1);

    // Overflow.
    run_stream("70000\n", 1'b0, 1'b0);
`ifdef DEPTH_SAT_EN
    chk("pin_ovf_height", dp_height, 65535);
    chk("pin_ovf_err", parse_err, 0);
`else
    chk("pin_ovf_height", dp_height, 4464);
    chk("pin_ovf_err", parse_err, 1);
`endif

    // Bubbly valid and a start pulse mid-run.
    run_stream("199\n200\n208\n", 1'b1, 1'b1);
    chk("pin_rand_height", dp_height, 208);
    chk("pin_rand_count", sample_count, 3);
    chk("pin_rand_err", parse_err, 0);

    // Zero samples: dp_height keeps the previous value.
    run_stream("\n", 1'b0, 1'b0);
    chk("pin_empty_count", sample_count, 0);
    chk("pin_empty_height", dp_height, 208);

    // Reset in the middle of accumulating "123".
    exp_q.delete();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    feed_byte("1", 1'b0, 1'b0, ok);
    feed_byte("2", 1'b0, 1'b0, ok);
    feed_byte("3", 1'b0, 1'b0, ok);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_stream("5\n", 1'b0, 1'b0);
    chk("pin_after_rst_height", dp_height, 5);
    chk("pin_after_rst_count", sample_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
